// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   AW_DEF               : address width of the default register count
//   reg_addr_t / xlen_t  : address and data types at default sizes
//   REG_ZERO             : address of the hardwired-zero register
package rf_pkg;
   localparam int XLEN_DEF  = 64;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);

   typedef logic [AW_DEF-1:0]   reg_addr_t;
   typedef logic [XLEN_DEF-1:0] xlen_t;

   localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file.
// It selects the stored value and the busy bit for the requested register.
//   rs           in  : register address for this port
//   regs         in  : current register contents
//   busy         in  : current scoreboard bits
//   write_enable in  : writeback strobe, with rd and write_data
//   read_data    out : operand value (x0 gives 0; a same-cycle writeback is forwarded)
//   rs_busy      out : operand still pending (a same-cycle writeback resolves it)
module rf_read_port
   import rf_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   localparam int AW   = $clog2(NREGS)
)(
   input  logic [AW-1:0]    rs,
   input  logic [XLEN-1:0]  regs [NREGS],
   input  logic [NREGS-1:0] busy,
   input  logic             write_enable,
   input  logic [AW-1:0]    rd,
   input  logic [XLEN-1:0]  write_data,
   output logic [XLEN-1:0]  read_data,
   output logic             rs_busy
);

   logic wb_hit;

   assign wb_hit = write_enable && (rd == rs);

   always_comb begin
      read_data = '0;
      rs_busy   = 1'b0;
      if (rs != '0) begin
         if (wb_hit) begin
            // The value retiring this cycle is newer than the array contents.
            read_data = write_data;
            rs_busy   = 1'b0;
         end else begin
            read_data = regs[rs];
            rs_busy   = busy[rs];
         end
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with write-through bypass and
// a busy-bit scoreboard for each register. x0 reads as zero and is never busy.
//   clk, rst      : clock and synchronous active-high reset
//   rs            : NREAD packed read addresses
//   read_data     : NREAD packed read values (combinational)
//   rs_busy       : per port, the operand is still pending (RAW hazard)
//   write_enable  : writeback strobe, with rd and write_data
//   issue_valid   : an instruction writing issue_rd issues this cycle
//   issue_waw     : issue_rd is already busy (advisory only)
//   busy_count    : registered number of busy registers
module regfile_sb
   import rf_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NREAD = 2,
   localparam int AW   = $clog2(NREGS)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREAD*AW-1:0]   rs,
   output logic [NREAD*XLEN-1:0] read_data,
   output logic [NREAD-1:0]      rs_busy,
   input  logic                  write_enable,
   input  logic [AW-1:0]         rd,
   input  logic [XLEN-1:0]       write_data,
   input  logic                  issue_valid,
   input  logic [AW-1:0]         issue_rd,
   output logic                  issue_waw,
   output logic [AW:0]           busy_count
);

   logic [XLEN-1:0]  regs_reg [NREGS];
   logic [NREGS-1:0] busy_reg;
   logic [NREGS-1:0] busy_next;
   logic [AW:0]      busy_count_reg;
   logic [AW:0]      busy_count_next;

   // Scoreboard next state. An issue in the same cycle as a writeback to the
   // same register wins: the new producer supersedes the one retiring.
   assign busy_next[0] = 1'b0;
   for (genvar gi = 1; gi < NREGS; gi++) begin : g_sb
      logic set, clr;
      assign set           = issue_valid  && (issue_rd == AW'(gi));
      assign clr           = write_enable && (rd == AW'(gi));
      assign busy_next[gi] = set | (busy_reg[gi] & ~clr);
   end

   // The count is computed from the next busy vector. It is then registered
   // with busy_reg, so it always matches the busy bits that are visible.
   always_comb begin
      busy_count_next = '0;
      for (int r = 1; r < NREGS; r++) begin
         busy_count_next = busy_count_next + {{AW{1'b0}}, busy_next[r]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_reg[r] <= '0;
         end
         busy_reg       <= '0;
         busy_count_reg <= '0;
      end else begin
         if (write_enable && (rd != '0)) begin
            regs_reg[rd] <= write_data;
         end
         busy_reg       <= busy_next;
         busy_count_reg <= busy_count_next;
      end
   end

   for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
      rf_read_port #(
         .XLEN  (XLEN),
         .NREGS (NREGS)
      ) u_port (
         .rs           (rs[gi*AW +: AW]),
         .regs         (regs_reg),
         .busy         (busy_reg),
         .write_enable (write_enable),
         .rd           (rd),
         .write_data   (write_data),
         .read_data    (read_data[gi*XLEN +: XLEN]),
         .rs_busy      (rs_busy[gi])
      );
   end

   // This flag does not look at a clear in the same cycle.
   assign issue_waw  = issue_valid && (issue_rd != '0) && busy_reg[issue_rd];
   assign busy_count = busy_count_reg;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb. It drives a default 64-bit 2-port
// instance and a 32-bit 4-port instance with the same write and issue traffic.
module tb_regfile_sb;
   import rf_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         write_enable;
   logic [4:0]   rd;
   logic [63:0]  write_data;
   logic         issue_valid;
   logic [4:0]   issue_rd;

   logic [9:0]   rs_a;
   logic [127:0] read_data_a;
   logic [1:0]   rs_busy_a;
   logic         issue_waw_a;
   logic [5:0]   busy_count_a;

   logic [19:0]  rs_b;
   logic [127:0] read_data_b;
   logic [3:0]   rs_busy_b;
   logic         issue_waw_b;
   logic [5:0]   busy_count_b;

   int n_checks = 0;
   int n_fail   = 0;
   int n_txn    = 0;

   // Reference state: architectural registers and pending-writer flags.
   logic [63:0] m_regs [32];
   bit          m_busy [32];

   always #5 clk = ~clk;

   regfile_sb dut_a (
      .clk          (clk),
      .rst          (rst),
      .rs           (rs_a),
      .read_data    (read_data_a),
      .rs_busy      (rs_busy_a),
      .write_enable (write_enable),
      .rd           (rd),
      .write_data   (write_data),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .issue_waw    (issue_waw_a),
      .busy_count   (busy_count_a)
   );

   regfile_sb #(.XLEN(32), .NREAD(4)) dut_b (
      .clk          (clk),
      .rst          (rst),
      .rs           (rs_b),
      .read_data    (read_data_b),
      .rs_busy      (rs_busy_b),
      .write_enable (write_enable),
      .rd           (rd),
      .write_data   (write_data[31:0]),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .issue_waw    (issue_waw_b),
      .busy_count   (busy_count_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s (txn %0d): got %0h, expected %0h", tag, n_txn, obs, exp);
      end
   endtask

   // Runs one clock cycle. It starts and ends at a negedge. The combinational
   // outputs are checked 1ns after the inputs are applied. The model is then
   // updated at the posedge.
   task automatic step(input bit r, input bit we, input logic [4:0] wrd, input logic [63:0] wd,
                       input bit iv, input logic [4:0] ird,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] a3);
      logic [4:0]  addr [4];
      logic [63:0] e_data;
      bit          e_busy;
      int          e_cnt;
      bit          e_waw;
      addr[0] = a0; addr[1] = a1; addr[2] = a2; addr[3] = a3;
      rst          = r;
      write_enable = we;
      rd           = wrd;
      write_data   = wd;
      issue_valid  = iv;
      issue_rd     = ird;
      rs_a         = {a1, a0};
      rs_b         = {a3, a2, a1, a0};
      $display("txn %0d rst=%0b we=%0b rd=%0d wd=%0h iv=%0b ird=%0d rs=%0d,%0d,%0d,%0d",
               n_txn, r, we, wrd, wd, iv, ird, a0, a1, a2, a3);
      #1;
      e_cnt = 0;
      for (int k = 0; k < 32; k++) e_cnt += int'(m_busy[k]);
      e_waw = iv && (ird != 5'd0) && m_busy[ird];
      for (int i = 0; i < 4; i++) begin
         if (addr[i] == 5'd0) begin
            e_data = 64'd0;
            e_busy = 1'b0;
         end else if (we && wrd == addr[i]) begin
            e_data = wd;
            e_busy = 1'b0;
         end else begin
            e_data = m_regs[addr[i]];
            e_busy = m_busy[addr[i]];
         end
         if (i < 2) begin
            check($sformatf("a_data%0d", i), read_data_a[i*64 +: 64], e_data);
            check($sformatf("a_busy%0d", i), 64'(rs_busy_a[i]), 64'(e_busy));
         end
         check($sformatf("b_data%0d", i), {32'd0, read_data_b[i*32 +: 32]}, {32'd0, e_data[31:0]});
         check($sformatf("b_busy%0d", i), 64'(rs_busy_b[i]), 64'(e_busy));
      end
      check("a_waw", 64'(issue_waw_a), 64'(e_waw));
      check("b_waw", 64'(issue_waw_b), 64'(e_waw));
      check("a_count", 64'(busy_count_a), 64'(e_cnt));
      check("b_count", 64'(busy_count_b), 64'(e_cnt));
      @(posedge clk);
      if (r) begin
         for (int k = 0; k < 32; k++) begin
            m_regs[k] = 64'd0;
            m_busy[k] = 1'b0;
         end
      end else begin
         if (we && wrd != 5'd0) begin
            m_regs[wrd] = wd;
            m_busy[wrd] = 1'b0;
         end
         // An issue is applied after the clear, so it wins.
         if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
      end
      n_txn++;
      @(negedge clk);
   endtask

   function automatic logic [4:0] pick_addr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin
      rst = 1'b1; write_enable = 1'b0; rd = '0; write_data = '0;
      issue_valid = 1'b0; issue_rd = '0; rs_a = '0; rs_b = '0;
      for (int k = 0; k < 32; k++) begin
         m_regs[k] = 64'd0;
         m_busy[k] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset: preload the array and the scoreboard, then reset.
      step(0, 1, 5'd7, 64'd11, 1, 5'd9, 0, 0, 0, 0);
      step(0, 1, 5'd8, 64'd22, 0, 0,    7, 8, 9, 0);
      step(1, 0, 0, 0, 0, 0,            7, 8, 9, 0);
      step(0, 0, 0, 0, 0, 0,            7, 8, 9, 0);

      // Write, read back, and bypass.
      step(0, 1, 5'd5, 64'd50,  0, 0, 0, 0, 0, 0);
      step(0, 1, 5'd6, 64'd200, 0, 0, 5, 6, 0, 0);
      step(0, 0, 0, 0,          0, 0, 5, 6, 0, 0);
      step(0, 1, 5'd5, 64'd77,  0, 0, 5, 6, 5, 6);
      step(0, 0, 0, 0,          0, 0, 5, 6, 5, 6);

      // x0: a write and an issue to x0 have no effect.
      step(0, 1, 5'd0, 64'd30, 1, 5'd0, 0, 0, 0, 0);
      step(0, 0, 0, 0,         0, 0,    0, 0, 0, 0);

      // RAW: issue, then pending, then resolved by writeback.
      step(0, 0, 0, 0,         1, 5'd3, 3, 0, 0, 0);
      step(0, 0, 0, 0,         0, 0,    3, 0, 3, 0);
      step(0, 1, 5'd3, 64'd20, 0, 0,    3, 0, 3, 0);
      step(0, 0, 0, 0,         0, 0,    3, 0, 3, 0);

      // Set wins over clear when the register is already busy.
      step(0, 0, 0, 0,        1, 5'd4, 0, 0, 0, 0);
      step(0, 1, 5'd4, 64'd9, 1, 5'd4, 4, 0, 4, 0);
      step(0, 0, 0, 0,        0, 0,    4, 0, 4, 0);
      step(0, 1, 5'd4, 64'd10, 0, 0,   4, 0, 4, 0);

      // All four ports of the wide instance read distinct values together.
      step(0, 1, 5'd1, 64'h1111_0001, 0, 0, 0, 0, 0, 0);
      step(0, 1, 5'd2, 64'h2222_0002, 0, 0, 0, 0, 0, 0);
      step(0, 1, 5'd3, 64'h3333_0003, 0, 0, 0, 0, 0, 0);
      step(0, 1, 5'd4, 64'h4444_0004, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 2, 3, 4);
      step(0, 0, 0, 0, 0, 0, 4, 3, 2, 1);

      // Random traffic. Addresses are biased toward a few registers so that
      // hazards, bypasses and set/clear collisions happen often.
      for (int t = 0; t < 400; t++) begin
         step($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, pick_addr(),
              {$urandom, $urandom}, $urandom_range(0, 2) == 0, pick_addr(),
              pick_addr(), pick_addr(), pick_addr(), pick_addr());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
